// File: rtl/dense_pkg.sv
// dense_pkg: shared types and helpers for the dense_stream_engine slice.
//   state_e    - engine FSM states (LOAD, MAC, OUT)
//   idx_w      - index width for a count of n items, never below 1 bit
//   acc_w      - accumulator width that cannot overflow for one neuron
//   sat_clamp  - signed saturation of a wide value to data_w bits
package dense_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // A one-element range still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int data_w, input int weight_w, input int in_size);
    return data_w + weight_w + $clog2(in_size + 1) + 1;
  endfunction

  // Clamp v into [-2^(data_w-1), 2^(data_w-1)-1]; sat reports whether it moved.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int data_w,
                                                   output logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    sat = 1'b0;
    sat_clamp = v;
    if (v > hi) begin
      sat = 1'b1;
      sat_clamp = hi;
    end else if (v < lo) begin
      sat = 1'b1;
      sat_clamp = lo;
    end
  endfunction

endpackage

// File: rtl/dense_stream_engine_mac.sv
// dense_mac_unit: signed multiply-accumulate for one output neuron.
//   clr_i        - zero the accumulator
//   bias_load_i  - acc = sign_extend(w_i) <<< FRAC_BITS (bias aligned to product scale)
//   acc_en_i     - acc += a_i * w_i, full precision
//   acc_o        - registered accumulator
// Priority: clr_i > bias_load_i > acc_en_i.
module dense_mac_unit #(
  parameter int DATA_W    = 16,
  parameter int WEIGHT_W  = 8,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       bias_load_i,
  input  logic                       acc_en_i,
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [WEIGHT_W-1:0] w_i,
  output logic signed [ACC_W-1:0]    acc_o
);

  localparam int PW = DATA_W + WEIGHT_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Both operands sign-extended to the product width so the result is exact.
  assign prod = PW'(a_i) * PW'(w_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (bias_load_i) begin
      acc_d = ACC_W'(w_i) <<< FRAC_BITS;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dense_stream_engine.sv
// dense_stream_engine: time-multiplexed fully-connected layer.
// A frame of IN_SIZE features is buffered (LOAD), then each of OUT_SIZE
// neurons is computed on a single MAC over IN_SIZE+1 cycles (MAC) and
// presented on a valid/ready output stream (OUT).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; valid never depends on ready, and out_data/out_idx/out_sat
// hold steady while out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     input feature stream, Q(FRAC_BITS)
//   out_valid/out_ready/out_data  output neuron stream, Q(FRAC_BITS)
//   out_idx, out_sat              neuron index and saturation flag of out_data
//   cfg_we/cfg_addr/cfg_data      weight/bias write; addr = o*(IN_SIZE+1)+i,
//                                 i == IN_SIZE selects bias[o]; ignored when busy
//   busy                          high outside LOAD
//   dbg_state                     current FSM state (state_e encoding)
// Optional (macro DENSE_ARGMAX_EN):
//   pred_valid, pred_idx          one-cycle pulse after the last neuron with the
//                                 index of the largest output (lowest index on ties)
module dense_stream_engine
  import dense_pkg::*;
#(
  parameter int IN_SIZE   = 32,
  parameter int OUT_SIZE  = 8,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int WEIGHT_W  = 8,
  parameter int W_FRAC    = 6,
  parameter int RELU      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic signed [DATA_W-1:0]                in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [DATA_W-1:0]                out_data,
  output logic [idx_w(OUT_SIZE)-1:0]              out_idx,
  output logic                                    out_sat,
  input  logic                                    cfg_we,
  input  logic [idx_w(OUT_SIZE*(IN_SIZE+1))-1:0]  cfg_addr,
  input  logic signed [WEIGHT_W-1:0]              cfg_data,
  output logic                                    busy,
  output logic [1:0]                              dbg_state
`ifdef DENSE_ARGMAX_EN
  ,
  output logic                                    pred_valid,
  output logic [idx_w(OUT_SIZE)-1:0]              pred_idx
`endif
);

  localparam int IDX_W  = idx_w(OUT_SIZE);
  localparam int DEPTH  = OUT_SIZE * (IN_SIZE + 1);
  localparam int ADDR_W = idx_w(DEPTH);
  localparam int MW     = idx_w(DEPTH + 1);  // wide enough to hold DEPTH itself
  localparam int CNT_W  = idx_w(IN_SIZE);
  localparam int CYC_W  = idx_w(IN_SIZE + 1);
  localparam int ACC_W  = acc_w(DATA_W, WEIGHT_W, IN_SIZE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_SIZE - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(IN_SIZE);
  localparam logic [IDX_W-1:0] O_LAST   = IDX_W'(OUT_SIZE - 1);
  localparam logic [MW-1:0]    ROW_M    = MW'(IN_SIZE + 1);
  localparam logic [MW-1:0]    DEPTH_M  = MW'(DEPTH);
  localparam logic [MW-1:0]    BIAS_OFF = MW'(IN_SIZE);

  // Storage is rounded up to a power of two so every index width is exact;
  // out-of-range config addresses are filtered before the write.
  logic signed [WEIGHT_W-1:0] wmem_q [2**ADDR_W];
  logic signed [DATA_W-1:0]   feat_q [2**CNT_W];

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CYC_W-1:0]         cyc_q, cyc_d;
  logic [IDX_W-1:0]         o_q, o_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic                     out_sat_q, out_sat_d;

  logic                     feat_we;
  logic                     mac_clr, mac_bias, mac_en;
  logic [MW-1:0]            w_off;
  logic [CNT_W-1:0]         f_idx;
  logic signed [WEIGHT_W-1:0] w_rd;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  res;
  logic signed [DATA_W-1:0] sat_val;
  logic                     sat_flag;

  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign busy      = (state_q != ST_LOAD);
  assign dbg_state = state_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_sat   = out_sat_q;

  // MAC cycle 0 reads the bias slot of the row; cycle k>0 reads weight k-1.
  always_comb begin
    w_off = (cyc_q == '0) ? BIAS_OFF : MW'(cyc_q - 1'b1);
    f_idx = (cyc_q == '0) ? '0 : CNT_W'(cyc_q - 1'b1);
  end

  assign w_rd = wmem_q[ADDR_W'(MW'(o_q) * ROW_M + w_off)];

  always_ff @(posedge clk) begin
    if (cfg_we && !busy && (MW'(cfg_addr) < DEPTH_M)) begin
      wmem_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (feat_we) begin
      feat_q[cnt_q] <= in_data;
    end
  end

  dense_mac_unit #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (mac_clr),
    .bias_load_i(mac_bias),
    .acc_en_i   (mac_en),
    .a_i        (feat_q[f_idx]),
    .w_i        (w_rd),
    .acc_o      (acc)
  );

  // Rescale to Q(FRAC_BITS) by flooring, optional ReLU, then saturate.
  always_comb begin
    res = acc >>> W_FRAC;
    if ((RELU != 0) && (res < 0)) begin
      res = '0;
    end
    sat_flag = 1'b0;
    sat_val  = DATA_W'(sat_clamp(64'(res), DATA_W, sat_flag));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_sat_d   = out_sat_q;
    feat_we     = 1'b0;
    mac_clr     = 1'b0;
    mac_bias    = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mac_clr = 1'b1;
        if (in_valid && in_ready) begin
          feat_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            cyc_d   = '0;
            o_d     = '0;
            state_d = ST_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        if (cyc_q == '0) begin
          mac_bias = 1'b1;
        end else begin
          mac_en = 1'b1;
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = ST_OUT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_OUT: begin
        // First OUT cycle registers the result; valid rises on the next edge.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_val;
          out_idx_d   = o_q;
          out_sat_d   = sat_flag;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (o_q == O_LAST) begin
            state_d = ST_LOAD;
          end else begin
            o_d     = o_q + 1'b1;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      cyc_q       <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_sat_q   <= out_sat_d;
    end
  end

`ifdef DENSE_ARGMAX_EN
  logic signed [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]         max_idx_q;
  logic                     pred_valid_q;
  logic [IDX_W-1:0]         pred_idx_q;
  logic                     out_hs;
  logic                     new_best;

  assign out_hs = out_valid_q && out_ready;
  // Neuron 0 always seeds the running max; strict '>' keeps the lowest index on ties.
  assign new_best = (out_idx_q == '0) || (out_data_q > max_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q        <= '0;
      max_idx_q    <= '0;
      pred_valid_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= 1'b0;
      if (out_hs) begin
        if (new_best) begin
          max_q     <= out_data_q;
          max_idx_q <= out_idx_q;
        end
        if (out_idx_q == O_LAST) begin
          pred_valid_q <= 1'b1;
          pred_idx_q   <= new_best ? out_idx_q : max_idx_q;
        end
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_idx   = pred_idx_q;
`endif

endmodule

// File: tb/tb_dense_stream_engine.sv
module tb_dense_stream_engine;

  localparam int IN  = 4;
  localparam int OUT = 2;
  localparam int DW  = 16;
  localparam int WW  = 8;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic out_ready = 1'b1;
  logic cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic signed [WW-1:0] cfg_data = '0;

  logic in_ready, out_valid, out_sat, busy;
  logic signed [DW-1:0] out_data;
  logic [0:0] out_idx;
  logic [1:0] dbg_state;

  logic nr_in_ready, nr_out_valid, nr_out_sat, nr_busy;
  logic signed [DW-1:0] nr_out_data;
  logic [0:0] nr_out_idx;
  logic [1:0] nr_dbg_state;
`ifdef DENSE_ARGMAX_EN
  logic pred_valid, nr_pred_valid;
  logic [0:0] pred_idx, nr_pred_idx;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [WW-1:0] w_m [OUT][IN+1];
  logic signed [DW-1:0] x_m [IN];
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_nr_q[$];

  dense_stream_engine #(
    .IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .FRAC_BITS(8),
    .WEIGHT_W(WW), .W_FRAC(6), .RELU(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_sat(out_sat), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .dbg_state(dbg_state)
`ifdef DENSE_ARGMAX_EN
    , .pred_valid(pred_valid), .pred_idx(pred_idx)
`endif
  );

  dense_stream_engine #(
    .IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .FRAC_BITS(8),
    .WEIGHT_W(WW), .W_FRAC(6), .RELU(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nr_in_ready), .in_data(in_data),
    .out_valid(nr_out_valid), .out_ready(out_ready), .out_data(nr_out_data), .out_idx(nr_out_idx),
    .out_sat(nr_out_sat), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(nr_busy), .dbg_state(nr_dbg_state)
`ifdef DENSE_ARGMAX_EN
    , .pred_valid(nr_pred_valid), .pred_idx(nr_pred_idx)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // out = sat(relu(floor((bias*2^8 + sum x*w) / 2^6))), returned as {sat, data}
  function automatic logic [DW:0] model_out(input int o, input bit relu);
    longint acc;
    longint res;
    logic sat;
    logic [DW:0] r;
    acc = longint'(w_m[o][IN]) * 256;
    for (int i = 0; i < IN; i++) acc += longint'(x_m[i]) * longint'(w_m[o][i]);
    res = acc >>> 6;
    if (relu && res < 0) res = 0;
    sat = 1'b0;
    if (res > 32767) begin
      res = 32767;
      sat = 1'b1;
    end else if (res < -32768) begin
      res = -32768;
      sat = 1'b1;
    end
    r = {sat, res[DW-1:0]};
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic cfg_write(input int addr, input logic signed [WW-1:0] d, input bit track);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (track) w_m[addr / (IN + 1)][addr % (IN + 1)] = d;
  endtask

  task automatic load_weights();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i <= IN; i++) cfg_write(o * (IN + 1) + i, w_m[o][i], 1'b0);
  endtask

  task automatic push_expected();
    for (int o = 0; o < OUT; o++) begin
      exp_q.push_back(model_out(o, 1'b1));
      exp_nr_q.push_back(model_out(o, 1'b0));
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < IN; i++) begin
      int n;
      in_valid = 1'b1;
      in_data = x_m[i];
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL in_ready_timeout feature %0d: in_ready=%b required 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: pop one expected entry per neuron and compare both instances.
  task automatic collect_frame(input bit rand_bp, input bit chk_lat, input string tag);
    for (int o = 0; o < OUT; o++) begin
      int n;
      int stall;
      logic [DW:0] e;
      logic [DW:0] enr;
      out_ready = rand_bp ? 1'b0 : 1'b1;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_valid_timeout neuron %0d: out_valid=%b required 1", tag, o, out_valid);
      end
      if (chk_lat) begin
        tests_run++;
        if (n !== IN + 2) begin
          tests_failed++;
          $display("FAIL %s_latency neuron %0d: got %0d cycles required %0d", tag, o, n, IN + 2);
        end
      end
      e = exp_q.pop_front();
      enr = exp_nr_q.pop_front();
      tests_run++;
      if (out_data !== e[DW-1:0]) begin
        tests_failed++;
        $display("FAIL %s_data neuron %0d: got %0d required %0d", tag, o, out_data, $signed(e[DW-1:0]));
      end
      tests_run++;
      if (out_sat !== e[DW]) begin
        tests_failed++;
        $display("FAIL %s_sat neuron %0d: got %b required %b", tag, o, out_sat, e[DW]);
      end
      tests_run++;
      if (out_idx !== 1'(o)) begin
        tests_failed++;
        $display("FAIL %s_idx: got %0d required %0d", tag, out_idx, o);
      end
      tests_run++;
      if (nr_out_data !== enr[DW-1:0] || nr_out_sat !== enr[DW]) begin
        tests_failed++;
        $display("FAIL %s_norelu neuron %0d: got %0d/%b required %0d/%b", tag, o,
                 nr_out_data, nr_out_sat, $signed(enr[DW-1:0]), enr[DW]);
      end
      if (rand_bp) begin
        stall = $urandom_range(0, 3);
        repeat (stall) tick();
      end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input bit rand_bp, input bit chk_lat, input string tag);
    push_expected();
    send_frame();
    collect_frame(rand_bp, chk_lat, tag);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 0/0/0", in_ready, out_valid, busy);
    end
    tests_run++;
    if (out_data !== 16'sd0 || out_idx !== 1'b0 || out_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: data=%0d idx=%0d sat=%b required 0/0/0", out_data, out_idx, out_sat);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    for (int o = 0; o < OUT; o++) begin
      for (int i = 0; i < IN; i++) w_m[o][i] = 8'sd64;
      w_m[o][IN] = 8'sd0;
    end
    x_m[0] = 16'sd256; x_m[1] = 16'sd512; x_m[2] = -16'sd256; x_m[3] = 16'sd0;
    load_weights();
    run_frame(1'b0, 1'b1, "basic");
  endtask

  task automatic test_bias();
    cfg_write(1 * (IN + 1) + IN, 8'sd64, 1'b1);
    run_frame(1'b0, 1'b0, "bias");
  endtask

  task automatic test_relu();
    for (int i = 0; i < IN; i++) cfg_write(i, -8'sd64, 1'b1);
    run_frame(1'b0, 1'b0, "relu");
  endtask

  task automatic test_saturation();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i <= IN; i++) w_m[o][i] = 8'sd127;
    for (int i = 0; i < IN; i++) x_m[i] = 16'sd32767;
    load_weights();
    run_frame(1'b0, 1'b0, "sat");
  endtask

  task automatic test_backpressure();
    logic [DW:0] e;
    int n;
    for (int o = 0; o < OUT; o++) begin
      for (int i = 0; i < IN; i++) w_m[o][i] = WW'($urandom_range(0, 255));
      w_m[o][IN] = WW'($urandom_range(0, 255));
    end
    for (int i = 0; i < IN; i++) x_m[i] = DW'(int'($urandom_range(0, 4000)) - 2000);
    load_weights();
    push_expected();
    send_frame();
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    e = exp_q[0];
    repeat (7) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== e[DW-1:0] || out_idx !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold: valid=%b data=%0d idx=%0d required 1/%0d/0",
                 out_valid, out_data, out_idx, $signed(e[DW-1:0]));
      end
    end
    collect_frame(1'b0, 1'b0, "bp");

    // Writes while busy are dropped: the model is deliberately not updated.
    push_expected();
    send_frame();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_frame: busy=%b required 1", busy);
    end
    cfg_write(0, 8'sh5A, 1'b0);
    cfg_write(IN + 1, -8'sh33, 1'b0);
    cfg_write(IN, 8'sh7F, 1'b0);
    collect_frame(1'b0, 1'b0, "cfg_busy");
    run_frame(1'b0, 1'b0, "cfg_busy_next");
  endtask

  task automatic test_reset_mid();
    int seen;
    send_frame();
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: busy=%b in_ready=%b required 0/0", busy, in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: in_ready=%b required 1", in_ready);
    end
    seen = 0;
    repeat (3 * (IN + 2) + 5) begin
      tick();
      if (out_valid === 1'b1 || nr_out_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_output: valid cycles=%0d required 0", seen);
    end
    for (int i = 0; i < IN; i++) x_m[i] = DW'(int'($urandom_range(0, 2000)) - 1000);
    run_frame(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int o = 0; o < OUT; o++)
        for (int i = 0; i <= IN; i++) w_m[o][i] = WW'($urandom_range(0, 255));
      for (int i = 0; i < IN; i++)
        x_m[i] = (f % 2 == 0) ? DW'($urandom_range(0, 65535)) : DW'(int'($urandom_range(0, 1000)) - 500);
      load_weights();
      run_frame(1'b1, 1'b0, "random");
    end
  endtask

`ifdef DENSE_ARGMAX_EN
  task automatic test_argmax();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i <= IN; i++) w_m[o][i] = 8'sd0;
    w_m[0][0] = 8'sd64;
    w_m[1][0] = 8'sd64;
    w_m[1][IN] = 8'sd50;
    x_m[0] = 16'sd100; x_m[1] = 16'sd0; x_m[2] = 16'sd0; x_m[3] = 16'sd0;
    load_weights();
    run_frame(1'b0, 1'b0, "argmax");
    tests_run++;
    if (pred_valid !== 1'b1 || pred_idx !== 1'b1) begin
      tests_failed++;
      $display("FAIL argmax_pulse: pred_valid=%b pred_idx=%0d required 1/1", pred_valid, pred_idx);
    end
    tick();
    tests_run++;
    if (pred_valid !== 1'b0 || pred_idx !== 1'b1) begin
      tests_failed++;
      $display("FAIL argmax_hold: pred_valid=%b pred_idx=%0d required 0/1", pred_valid, pred_idx);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_relu();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef DENSE_ARGMAX_EN
    test_argmax();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
